// File: rtl/draw_rect_array.sv
// N-slot rectangle hit tester: host writes a shadow bank that is committed to the
// active bank on frame_start_in, and every pixel is tested against the active bank.
module draw_rect_array #(
  parameter int N_RECTS = 4,
  parameter int LATENCY = 4,
  parameter int BORDER  = 0,
  localparam int IW = (N_RECTS > 1) ? $clog2(N_RECTS) : 1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               wr_en_in,
  input  logic [IW-1:0]      wr_idx_in,
  input  logic [10:0]        wr_x1_in,
  input  logic [9:0]         wr_y1_in,
  input  logic [10:0]        wr_x2_in,
  input  logic [9:0]         wr_y2_in,
  input  logic [23:0]        wr_color_in,
  input  logic               wr_enable_in,
  input  logic               frame_start_in,
  input  logic               valid_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  output logic [N_RECTS-1:0] hit_vec_out,
  output logic               hit_out,
  output logic [IW-1:0]      hit_idx_out,
  output logic [23:0]        color_out,
  output logic               valid_out
);

  // Stage 3 plus the LATENCY-3 padding stages.
  localparam int NP = (LATENCY >= 3) ? LATENCY - 2 : 1;

  if (LATENCY < 3) begin : g_latency_check
    $error("draw_rect_array: LATENCY must be >= 3");
  end

  logic [10:0]        sh_x1_q [N_RECTS];
  logic [10:0]        sh_x2_q [N_RECTS];
  logic [9:0]         sh_y1_q [N_RECTS];
  logic [9:0]         sh_y2_q [N_RECTS];
  logic [23:0]        sh_col_q [N_RECTS];
  logic [N_RECTS-1:0] sh_en_q;
  logic [10:0]        act_x1_q [N_RECTS];
  logic [10:0]        act_x2_q [N_RECTS];
  logic [9:0]         act_y1_q [N_RECTS];
  logic [9:0]         act_y2_q [N_RECTS];
  logic [23:0]        act_col_q [N_RECTS];
  logic [N_RECTS-1:0] act_en_q;

  logic [10:0] wr_x_lo, wr_x_hi;
  logic [9:0]  wr_y_lo, wr_y_hi;
  logic        wr_ok;

  always_comb begin
    wr_x_lo = (wr_x1_in < wr_x2_in) ? wr_x1_in : wr_x2_in;
    wr_x_hi = (wr_x1_in < wr_x2_in) ? wr_x2_in : wr_x1_in;
    wr_y_lo = (wr_y1_in < wr_y2_in) ? wr_y1_in : wr_y2_in;
    wr_y_hi = (wr_y1_in < wr_y2_in) ? wr_y2_in : wr_y1_in;
    wr_ok   = wr_en_in && (32'(wr_idx_in) < N_RECTS);
  end

  // Commit copies the pre-write shadow; a same-cycle write lands in shadow only.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_RECTS; i++) begin
        sh_x1_q[i]   <= '0;
        sh_x2_q[i]   <= '0;
        sh_y1_q[i]   <= '0;
        sh_y2_q[i]   <= '0;
        sh_col_q[i]  <= '0;
        act_x1_q[i]  <= '0;
        act_x2_q[i]  <= '0;
        act_y1_q[i]  <= '0;
        act_y2_q[i]  <= '0;
        act_col_q[i] <= '0;
      end
      sh_en_q  <= '0;
      act_en_q <= '0;
    end else begin
      if (frame_start_in) begin
        for (int i = 0; i < N_RECTS; i++) begin
          act_x1_q[i]  <= sh_x1_q[i];
          act_x2_q[i]  <= sh_x2_q[i];
          act_y1_q[i]  <= sh_y1_q[i];
          act_y2_q[i]  <= sh_y2_q[i];
          act_col_q[i] <= sh_col_q[i];
        end
        act_en_q <= sh_en_q;
      end
      if (wr_ok) begin
        sh_x1_q[wr_idx_in]  <= wr_x_lo;
        sh_x2_q[wr_idx_in]  <= wr_x_hi;
        sh_y1_q[wr_idx_in]  <= wr_y_lo;
        sh_y2_q[wr_idx_in]  <= wr_y_hi;
        sh_col_q[wr_idx_in] <= wr_color_in;
        sh_en_q[wr_idx_in]  <= wr_enable_in;
      end
    end
  end

  // Inner box uses one extra bit so x1+B cannot wrap; x2-B clamps at zero.
  function automatic logic rect_hit(input logic en, input logic [10:0] x1, input logic [10:0] x2,
                                    input logic [9:0] y1, input logic [9:0] y2,
                                    input logic [10:0] h, input logic [9:0] v);
    logic        filled, inner;
    logic [11:0] ix_lo, ix_hi;
    logic [10:0] iy_lo, iy_hi;
    filled = en && (h >= x1) && (h < x2) && (v >= y1) && (v < y2);
    ix_lo  = {1'b0, x1} + 12'(BORDER);
    ix_hi  = ({1'b0, x2} > 12'(BORDER)) ? {1'b0, x2} - 12'(BORDER) : 12'd0;
    iy_lo  = {1'b0, y1} + 11'(BORDER);
    iy_hi  = ({1'b0, y2} > 11'(BORDER)) ? {1'b0, y2} - 11'(BORDER) : 11'd0;
    inner  = ({1'b0, h} >= ix_lo) && ({1'b0, h} < ix_hi) &&
             ({1'b0, v} >= iy_lo) && ({1'b0, v} < iy_hi);
    return (BORDER > 0) ? (filled && !inner) : filled;
  endfunction

  logic [10:0]        h1_q;
  logic [9:0]         v1_q;
  logic               val1_q;
  logic [N_RECTS-1:0] hit_c;
  logic [N_RECTS-1:0] hit2_q;
  logic               val2_q;
  logic [23:0]        col2_q [N_RECTS];
  logic               s3_hit;
  logic [IW-1:0]      s3_idx;
  logic [23:0]        s3_col;

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < N_RECTS; i++) begin
      hit_c[i] = val1_q && rect_hit(act_en_q[i], act_x1_q[i], act_x2_q[i],
                                    act_y1_q[i], act_y2_q[i], h1_q, v1_q);
    end
  end

  // Colours are snapshotted alongside the hits so a commit between stages 2 and 3
  // cannot pair one bank's hit with another bank's colour.
  always_comb begin
    s3_hit = |hit2_q;
    s3_idx = '0;
    s3_col = '0;
    for (int i = N_RECTS - 1; i >= 0; i--) begin
      if (hit2_q[i]) begin
        s3_idx = IW'(i);
        s3_col = col2_q[i];
      end
    end
  end

  logic [N_RECTS-1:0] p_vec_q [NP];
  logic [IW-1:0]      p_idx_q [NP];
  logic [23:0]        p_col_q [NP];
  logic [NP-1:0]      p_hit_q;
  logic [NP-1:0]      p_val_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h1_q    <= '0;
      v1_q    <= '0;
      val1_q  <= 1'b0;
      hit2_q  <= '0;
      val2_q  <= 1'b0;
      p_hit_q <= '0;
      p_val_q <= '0;
      for (int i = 0; i < N_RECTS; i++) col2_q[i] <= '0;
      for (int i = 0; i < NP; i++) begin
        p_vec_q[i] <= '0;
        p_idx_q[i] <= '0;
        p_col_q[i] <= '0;
      end
    end else begin
      h1_q   <= hcount_in;
      v1_q   <= vcount_in;
      val1_q <= valid_in;
      hit2_q <= hit_c;
      val2_q <= val1_q;
      for (int i = 0; i < N_RECTS; i++) col2_q[i] <= act_col_q[i];
      p_vec_q[0] <= hit2_q;
      p_hit_q[0] <= s3_hit;
      p_idx_q[0] <= s3_idx;
      p_col_q[0] <= s3_col;
      p_val_q[0] <= val2_q;
      for (int i = 1; i < NP; i++) begin
        p_vec_q[i] <= p_vec_q[i-1];
        p_hit_q[i] <= p_hit_q[i-1];
        p_idx_q[i] <= p_idx_q[i-1];
        p_col_q[i] <= p_col_q[i-1];
        p_val_q[i] <= p_val_q[i-1];
      end
    end
  end

  assign hit_vec_out = p_vec_q[NP-1];
  assign hit_out     = p_hit_q[NP-1];
  assign hit_idx_out = p_idx_q[NP-1];
  assign color_out   = p_col_q[NP-1];
  assign valid_out   = p_val_q[NP-1];

endmodule

// File: tb/tb_draw_rect_array.sv
// Bench for draw_rect_array: a filled and an outline (BORDER=2) instance share stimulus;
// directed tables plus random traffic checked against a bank/pixel reference model.
module tb_draw_rect_array;
  localparam int NR  = 5;
  localparam int LAT = 4;
  localparam int B_O = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_enable, frame_start, valid;
  logic [2:0]  wr_idx;
  logic [10:0] wr_x1, wr_x2, hcount;
  logic [9:0]  wr_y1, wr_y2, vcount;
  logic [23:0] wr_color;

  logic [4:0]  f_vec, o_vec;
  logic        f_hit, o_hit, f_val, o_val;
  logic [2:0]  f_idx, o_idx;
  logic [23:0] f_col, o_col;
  logic [33:0] f_word, o_word;
  assign f_word = {f_val, f_vec, f_hit, f_idx, f_col};
  assign o_word = {o_val, o_vec, o_hit, o_idx, o_col};

  always #5 clk = ~clk;

  draw_rect_array #(.N_RECTS(NR), .LATENCY(LAT), .BORDER(0)) u_fill (
    .clk_in(clk), .rst_n_in(rst_n), .wr_en_in(wr_en), .wr_idx_in(wr_idx),
    .wr_x1_in(wr_x1), .wr_y1_in(wr_y1), .wr_x2_in(wr_x2), .wr_y2_in(wr_y2),
    .wr_color_in(wr_color), .wr_enable_in(wr_enable), .frame_start_in(frame_start),
    .valid_in(valid), .hcount_in(hcount), .vcount_in(vcount),
    .hit_vec_out(f_vec), .hit_out(f_hit), .hit_idx_out(f_idx), .color_out(f_col),
    .valid_out(f_val));

  draw_rect_array #(.N_RECTS(NR), .LATENCY(LAT), .BORDER(B_O)) u_line (
    .clk_in(clk), .rst_n_in(rst_n), .wr_en_in(wr_en), .wr_idx_in(wr_idx),
    .wr_x1_in(wr_x1), .wr_y1_in(wr_y1), .wr_x2_in(wr_x2), .wr_y2_in(wr_y2),
    .wr_color_in(wr_color), .wr_enable_in(wr_enable), .frame_start_in(frame_start),
    .valid_in(valid), .hcount_in(hcount), .vcount_in(vcount),
    .hit_vec_out(o_vec), .hit_out(o_hit), .hit_idx_out(o_idx), .color_out(o_col),
    .valid_out(o_val));

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_f_q[$];
  logic [33:0] exp_o_q[$];

  // Reference banks: plain integer rectangles
  int          sh_x1[NR], sh_y1[NR], sh_x2[NR], sh_y2[NR];
  int          ac_x1[NR], ac_y1[NR], ac_x2[NR], ac_y2[NR];
  logic [23:0] sh_col[NR], ac_col[NR];
  bit          sh_en[NR], ac_en[NR];

  typedef struct {
    int h; int v;
    logic [4:0] vf; logic [2:0] idf; logic [23:0] cf;
    logic [4:0] vo; logic [2:0] ido; logic [23:0] co;
  } vec_t;
  vec_t t2[6];
  vec_t t5[7];

  function automatic logic [33:0] word(logic vld, logic [4:0] vec, logic [2:0] idx, logic [23:0] col);
    return {vld, vec, |vec, idx, col};
  endfunction

  task automatic check(string name, logic [33:0] got, logic [33:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      sh_x1[i] = 0; sh_y1[i] = 0; sh_x2[i] = 0; sh_y2[i] = 0; sh_col[i] = 0; sh_en[i] = 0;
      ac_x1[i] = 0; ac_y1[i] = 0; ac_x2[i] = 0; ac_y2[i] = 0; ac_col[i] = 0; ac_en[i] = 0;
    end
    exp_f_q.delete();
    exp_o_q.delete();
    repeat (LAT - 1) begin
      exp_f_q.push_back(34'd0);
      exp_o_q.push_back(34'd0);
    end
  endtask

  task automatic model_edge();
    int k;
    if (frame_start) begin
      ac_x1 = sh_x1; ac_y1 = sh_y1; ac_x2 = sh_x2; ac_y2 = sh_y2; ac_col = sh_col; ac_en = sh_en;
    end
    k = int'(wr_idx);
    if (wr_en && k < NR) begin
      sh_x1[k] = (wr_x1 < wr_x2) ? int'(wr_x1) : int'(wr_x2);
      sh_x2[k] = (wr_x1 < wr_x2) ? int'(wr_x2) : int'(wr_x1);
      sh_y1[k] = (wr_y1 < wr_y2) ? int'(wr_y1) : int'(wr_y2);
      sh_y2[k] = (wr_y1 < wr_y2) ? int'(wr_y2) : int'(wr_y1);
      sh_col[k] = wr_color;
      sh_en[k]  = wr_enable;
    end
  endtask

  function automatic bit ref_hit(int i, int h, int v, int b);
    bit filled, inner;
    int ihx, ihy;
    filled = ac_en[i] && ac_x1[i] <= h && h < ac_x2[i] && ac_y1[i] <= v && v < ac_y2[i];
    if (b == 0) return filled;
    ihx = (ac_x2[i] - b < 0) ? 0 : ac_x2[i] - b;
    ihy = (ac_y2[i] - b < 0) ? 0 : ac_y2[i] - b;
    inner = (ac_x1[i] + b <= h) && (h < ihx) && (ac_y1[i] + b <= v) && (v < ihy);
    return filled && !inner;
  endfunction

  function automatic logic [33:0] model_out(int b, logic val, int h, int v);
    logic [4:0]  vec = '0;
    logic [2:0]  idx = '0;
    logic [23:0] col = '0;
    bit          found = 0;
    if (val) begin
      for (int i = 0; i < NR; i++) begin
        vec[i] = ref_hit(i, h, v, b);
        if (vec[i] && !found) begin
          found = 1; idx = 3'(i); col = ac_col[i];
        end
      end
    end
    return {val, vec, |vec, idx, col};
  endfunction

  task automatic step(logic fs, logic val, int h, int v);
    frame_start = fs; valid = val; hcount = 11'(h); vcount = 10'(v);
    @(posedge clk);
    model_edge();
    exp_f_q.push_back(model_out(0, val, h, v));
    exp_o_q.push_back(model_out(B_O, val, h, v));
    #1;
    if (exp_f_q.size() >= LAT) begin
      check("sb_fill", f_word, exp_f_q.pop_front());
      check("sb_line", o_word, exp_o_q.pop_front());
    end
    frame_start = 0; valid = 0; wr_en = 0;
  endtask

  task automatic wr(int idx, int x1, int y1, int x2, int y2, logic [23:0] col, logic en, logic fs);
    wr_en = 1; wr_idx = 3'(idx);
    wr_x1 = 11'(x1); wr_y1 = 10'(y1); wr_x2 = 11'(x2); wr_y2 = 10'(y2);
    wr_color = col; wr_enable = en;
    step(fs, 0, 0, 0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) wr(i, 0, 0, 0, 0, 24'h0, 1'b0, 1'b0);
    step(1, 0, 0, 0);
  endtask

  task automatic probe(string name, logic val, int h, int v,
                       logic [4:0] vf, logic [2:0] idf, logic [23:0] cf,
                       logic [4:0] vo, logic [2:0] ido, logic [23:0] co);
    step(0, val, h, v);
    repeat (LAT - 2) step(0, 0, 0, 0);
    check({name, "_early"}, {33'd0, f_val}, 34'd0);
    step(0, 0, 0, 0);
    check({name, "_fill"}, f_word, word(val, vf, idf, cf));
    check({name, "_line"}, o_word, word(val, vo, ido, co));
  endtask

  initial begin
    t2[0] = '{10, 5, 5'b00001, 3'd0, 24'hFF0000, 5'b00001, 3'd0, 24'hFF0000};
    t2[1] = '{30, 20, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0};
    t2[2] = '{9, 5, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0};
    t2[3] = '{29, 4, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0};
    t2[4] = '{20, 12, 5'b00001, 3'd0, 24'hFF0000, 5'b0, 3'd0, 24'h0};
    t2[5] = '{29, 19, 5'b00001, 3'd0, 24'hFF0000, 5'b00001, 3'd0, 24'hFF0000};
    t5[0] = '{11, 15, 5'b00001, 3'd0, 24'h123456, 5'b00001, 3'd0, 24'h123456};
    t5[1] = '{18, 15, 5'b00001, 3'd0, 24'h123456, 5'b00001, 3'd0, 24'h123456};
    t5[2] = '{12, 15, 5'b00001, 3'd0, 24'h123456, 5'b0, 3'd0, 24'h0};
    t5[3] = '{17, 15, 5'b00001, 3'd0, 24'h123456, 5'b0, 3'd0, 24'h0};
    t5[4] = '{41, 20, 5'b00010, 3'd1, 24'hABCDEF, 5'b00010, 3'd1, 24'hABCDEF};
    t5[5] = '{42, 29, 5'b00010, 3'd1, 24'hABCDEF, 5'b00010, 3'd1, 24'hABCDEF};
    t5[6] = '{43, 20, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0};

    wr_en = 0; wr_idx = 0; wr_x1 = 0; wr_y1 = 0; wr_x2 = 0; wr_y2 = 0;
    wr_color = 0; wr_enable = 0; frame_start = 0; valid = 0; hcount = 0; vcount = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check("reset_fill", f_word, 34'd0);
    check("reset_line", o_word, 34'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // T2 single filled rectangle, corners given reversed
    wr(0, 30, 20, 10, 5, 24'hFF0000, 1, 0);
    step(1, 0, 0, 0);
    foreach (t2[i])
      probe($sformatf("t2_%0d", i), 1, t2[i].h, t2[i].v,
            t2[i].vf, t2[i].idf, t2[i].cf, t2[i].vo, t2[i].ido, t2[i].co);

    // T1 async reset while hits are in flight
    for (int k = 0; k < 6; k++) step(0, 1, 10 + k, 5);
    rst_n = 0;
    #1;
    check("rst_mid_fill", f_word, 34'd0);
    check("rst_mid_line", o_word, 34'd0);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    probe("t1_after", 1, 10, 5, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    wr(0, 10, 5, 30, 20, 24'hFF0000, 1, 0);
    probe("t1_nocommit", 1, 10, 5, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    step(1, 0, 0, 0);
    probe("t1_commit", 1, 10, 5, 5'b00001, 3'd0, 24'hFF0000, 5'b00001, 3'd0, 24'hFF0000);

    // T3 priority
    clear_all();
    wr(0, 0, 0, 100, 100, 24'h00FF00, 1, 0);
    wr(2, 50, 50, 60, 60, 24'h0000FF, 1, 0);
    step(1, 0, 0, 0);
    probe("t3_pri", 1, 55, 55, 5'b00101, 3'd0, 24'h00FF00, 5'b0, 3'd0, 24'h0);
    probe("t3_edge", 1, 50, 55, 5'b00101, 3'd0, 24'h00FF00, 5'b00100, 3'd2, 24'h0000FF);
    wr(0, 0, 0, 100, 100, 24'h00FF00, 0, 0);
    step(1, 0, 0, 0);
    probe("t3_dis", 1, 55, 55, 5'b00100, 3'd2, 24'h0000FF, 5'b0, 3'd0, 24'h0);

    // T4 shadow/commit timing
    clear_all();
    wr(1, 0, 0, 8, 8, 24'h111111, 1, 0);
    probe("t4_nocommit", 1, 0, 4, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    wr(1, 0, 0, 8, 8, 24'h111111, 0, 0);
    wr(1, 0, 0, 8, 8, 24'h111111, 1, 1);
    probe("t4_samecyc", 1, 0, 4, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    step(1, 0, 0, 0);
    probe("t4_commit", 1, 0, 4, 5'b00010, 3'd1, 24'h111111, 5'b00010, 3'd1, 24'h111111);

    // T5 outline vs filled
    clear_all();
    wr(0, 10, 10, 20, 20, 24'h123456, 1, 0);
    wr(1, 40, 10, 43, 30, 24'hABCDEF, 1, 0);
    step(1, 0, 0, 0);
    foreach (t5[i])
      probe($sformatf("t5_%0d", i), 1, t5[i].h, t5[i].v,
            t5[i].vf, t5[i].idf, t5[i].cf, t5[i].vo, t5[i].ido, t5[i].co);

    // T6 degenerate, out-of-range index, invalid pixel
    clear_all();
    wr(3, 7, 0, 7, 50, 24'h222222, 1, 0);
    step(1, 0, 0, 0);
    probe("t6_zero_w", 1, 7, 10, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    for (int k = 5; k < 8; k++) wr(k, 0, 0, 100, 100, 24'h333333, 1, 0);
    step(1, 0, 0, 0);
    probe("t6_badidx", 1, 20, 20, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    wr(4, 0, 0, 100, 100, 24'h444444, 1, 0);
    step(1, 0, 0, 0);
    probe("t6_novalid", 0, 1, 20, 5'b0, 3'd0, 24'h0, 5'b0, 3'd0, 24'h0);
    probe("t6_valid", 1, 1, 20, 5'b10000, 3'd4, 24'h444444, 5'b10000, 3'd4, 24'h444444);

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(7) == 0) begin
        wr_en = 1; wr_idx = 3'($urandom_range(7));
        wr_x1 = 11'($urandom_range(63)); wr_x2 = 11'($urandom_range(63));
        wr_y1 = 10'($urandom_range(63)); wr_y2 = 10'($urandom_range(63));
        wr_color = 24'($urandom); wr_enable = ($urandom_range(3) != 0);
      end
      step($urandom_range(15) == 0, $urandom_range(3) != 0,
           int'($urandom_range(63)), int'($urandom_range(63)));
    end
    repeat (LAT) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
